// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and default width for the PISO serializer
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    localparam int PISO_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_PAR   = ST_PAR
    } piso_state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - bit counter with clear, enable and terminal flag at WIDTH-1
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter paced by bit_en
// Optional even parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    piso_state_t      state, state_next;
    logic [WIDTH-1:0] sreg;
    logic             capture, shift, finish, last;
`ifdef PISO_PARITY_EN
    logic             parity, par_out;
`endif

    wire head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (shift),
        .last  (last)
    );

    assign din_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
`ifdef PISO_PARITY_EN
        par_out    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (din_valid) begin
                    capture    = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    shift = 1'b1;
                    if (last) begin
`ifdef PISO_PARITY_EN
                        state_next = S_PAR;
`else
                        state_next = S_IDLE;
                        finish     = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            S_PAR: begin
                if (bit_en) begin
                    par_out    = 1'b1;
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Output flags are registered alongside the state so they line up with the bit on sout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg       <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            busy <= (state_next != S_IDLE);
            done <= finish;
`ifdef PISO_PARITY_EN
            sout_valid <= shift | par_out;
            if (par_out) begin
                sout <= parity;
            end
`else
            sout_valid <= shift;
`endif
            if (capture) begin
                sreg <= din;
`ifdef PISO_PARITY_EN
                parity <= ^din;
`endif
            end else if (shift) begin
                sout <= head;
                sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench driving MSB-first and LSB-first instances in parallel
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         bit_en;
    logic [1:0]   din_ready_v, sout_v, sout_valid_v, busy_v, done_v;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int be_period = 1;

    bit m_busy, m_valid, m_done;
    int m_cnt;
    bit last_s [2];
    bit q [2][$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_v[0]), .bit_en(bit_en), .sout(sout_v[0]),
        .sout_valid(sout_valid_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_v[1]), .bit_en(bit_en), .sout(sout_v[1]),
        .sout_valid(sout_valid_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph = 0;
        bit_en = 1'b0;
        forever begin
            @(negedge clk);
            bit_en = (ph == 0);
            ph = (ph + 1 >= be_period) ? 0 : ph + 1;
        end
    end

    // Reference model updates on the rising edge; DUT outputs are compared on the falling edge.
    initial begin
        bit b;
        forever begin
            @(posedge clk);
            cyc++;
            m_valid = 1'b0;
            m_done  = 1'b0;
            if (!rst_n) begin
                m_busy = 1'b0;
                m_cnt  = 0;
                for (int k = 0; k < 2; k++) begin
                    q[k].delete();
                    last_s[k] = 1'b0;
                end
            end else if (!m_busy) begin
                if (din_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    for (int i = 0; i < W; i++) begin
                        q[0].push_back(din[W-1-i]);
                        q[1].push_back(din[i]);
                    end
                    if (NB > W) begin
                        q[0].push_back(^din);
                        q[1].push_back(^din);
                    end
                end
            end else if (bit_en) begin
                m_valid = 1'b1;
                m_cnt++;
                if (m_cnt == NB) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("din_ready%0d", k), din_ready_v[k], !m_busy);
                check($sformatf("busy%0d", k), busy_v[k], m_busy);
                check($sformatf("sout_valid%0d", k), sout_valid_v[k], m_valid);
                check($sformatf("done%0d", k), done_v[k], m_done);
                if (m_valid) begin
                    if (q[k].size() == 0) begin
                        check($sformatf("sb_underflow%0d", k), 1, 0);
                    end else begin
                        b = q[k].pop_front();
                        check($sformatf("sout%0d", k), sout_v[k], b);
                        last_s[k] = b;
                    end
                end else begin
                    check($sformatf("sout_hold%0d", k), sout_v[k], last_s[k]);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_clk);
        for (int i = 0; i < max_clk; i++) begin
            if (!m_busy) begin
                for (int k = 0; k < 2; k++)
                    check($sformatf("sb_drained%0d", k), q[k].size(), 0);
                return;
            end
            step();
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic send(input logic [W-1:0] w, input bit hold);
        din = w;
        din_valid = 1'b1;
        step();
        check("captured", busy_v, 2'b11);
        if (!hold) din_valid = 1'b0;
    endtask

    initial begin
        int d;
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // MSB/LSB ordering at full bit rate, then a sparse single-one word at one bit per 3 clks
        be_period = 1;
        send(16'hA5C3, 1'b0);
        wait_idle(100);
        step();
        be_period = 3;
        send(16'h0001, 1'b0);
        wait_idle(200);

        // Back-to-back: valid held high, second capture one clk after done
        be_period = 1;
        send(16'hFFFF, 1'b1);
        din = 16'h0000;
        d = 0;
        for (int i = 0; i < 100 && !done_v[0]; i++) step();
        check("btb_done_seen", done_v[0], 1'b1);
        check("btb_idle_at_done", busy_v[0], 1'b0);
        step();
        check("btb_recapture", busy_v[0], 1'b1);
        din_valid = 1'b0;
        wait_idle(100);

        // Word change while busy must not disturb the frame in flight
        send(16'hA5C3, 1'b1);
        repeat (5) step();
        din = 16'h1234;
        repeat (3) step();
        check("ignore_ready", din_ready_v, 2'b00);
        din_valid = 1'b0;
        wait_idle(100);

        // Parity-relevant words and a few random ones at random bit rates
        send(16'h0007, 1'b0);
        wait_idle(100);
        send(16'h0003, 1'b0);
        wait_idle(100);
        for (int n = 0; n < 6; n++) begin
            be_period = $urandom_range(1, 4);
            send(16'($urandom), 1'b0);
            wait_idle(300);
        end

        // Reset mid-frame drops the word and produces no done
        be_period = 1;
        send(16'hBEEF, 1'b0);
        repeat (6) step();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_outputs", {sout_v, sout_valid_v, busy_v, done_v}, 8'h00);
        rst_n = 1'b1;
        step();
        check("rst_ready", din_ready_v, 2'b11);
        repeat (4) step();
        check("rst_no_done", done_v, 2'b00);

        send(16'h5A3C, 1'b0);
        wait_idle(100);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
